// File: rtl/secded_decoder.sv
// SEC-DED decoder for 16-bit Hamming codewords carrying 11 data bits.
// Takes two codeword bytes (low first) on a valid/ready stream and returns
// two result bytes (low first). The high result byte carries the status flags.
//
// state  | meaning
// -------+---------------------------------------------------------------
// GET_LO | waiting for codeword bits [7:0]
// GET_HI | waiting for codeword bits [15:8]
// CALC   | one cycle: syndrome, correction, result and counter update
// PUT_LO | presenting data bits [8:1] until the consumer takes them
// PUT_HI | presenting {flags, 000, data[11:9]} until the consumer takes it
module secded_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic [1:0]       flags,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    typedef enum logic [2:0] {
        GET_LO = 3'd0,
        GET_HI = 3'd1,
        CALC   = 3'd2,
        PUT_LO = 3'd3,
        PUT_HI = 3'd4
    } state_t;

    localparam logic [1:0] FLAG_CLEAN  = 2'b00;
    localparam logic [1:0] FLAG_SINGLE = 2'b01;
    localparam logic [1:0] FLAG_DOUBLE = 2'b10;

    state_t state, state_nxt;

    logic [7:0]  cw_lo;
    logic [7:0]  cw_hi;
    logic [7:0]  res_hi;
    logic [15:0] cw;

    logic        in_xfer;
    logic        out_xfer;

    logic [3:0]  syn;
    logic        par;
    logic [10:0] data_raw;
    logic [10:0] data_flip;
    logic [10:0] data_fix;
    logic [1:0]  flags_calc;
    logic [7:0]  lo_calc;
    logic [7:0]  hi_calc;

    assign cw = {cw_hi, cw_lo};

    // Input side is open only while collecting a codeword, and never during reset.
    assign in_ready = ((state == GET_LO) || (state == GET_HI)) && !reset;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Syndrome bit i is the parity of every position whose index has bit i set.
    always_comb begin
        syn[0] = ^(cw & 16'hAAAA);
        syn[1] = ^(cw & 16'hCCCC);
        syn[2] = ^(cw & 16'hF0F0);
        syn[3] = ^(cw & 16'hFF00);
        par    = ^cw;
    end

    // Map the syndrome onto the data bit it points at; parity positions map to nothing.
    always_comb begin
        data_raw  = {cw[15:9], cw[7:5], cw[3]};
        data_flip = '0;
        if (par) begin
            case (syn)
                4'd3:    data_flip = 11'b000_0000_0001;
                4'd5:    data_flip = 11'b000_0000_0010;
                4'd6:    data_flip = 11'b000_0000_0100;
                4'd7:    data_flip = 11'b000_0000_1000;
                4'd9:    data_flip = 11'b000_0001_0000;
                4'd10:   data_flip = 11'b000_0010_0000;
                4'd11:   data_flip = 11'b000_0100_0000;
                4'd12:   data_flip = 11'b000_1000_0000;
                4'd13:   data_flip = 11'b001_0000_0000;
                4'd14:   data_flip = 11'b010_0000_0000;
                4'd15:   data_flip = 11'b100_0000_0000;
                default: data_flip = '0;
            endcase
        end
        data_fix = data_raw ^ data_flip;
    end

    // Classify the word and assemble both result bytes.
    always_comb begin
        flags_calc = FLAG_CLEAN;
        if (par) begin
            flags_calc = FLAG_SINGLE;
        end else if (syn != 4'd0) begin
            flags_calc = FLAG_DOUBLE;
        end
        lo_calc = data_fix[7:0];
        hi_calc = {flags_calc, 3'b000, data_fix[10:8]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= GET_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            GET_LO:  if (in_xfer)  state_nxt = GET_HI;
            GET_HI:  if (in_xfer)  state_nxt = CALC;
            CALC:                  state_nxt = PUT_LO;
            PUT_LO:  if (out_xfer) state_nxt = PUT_HI;
            PUT_HI:  if (out_xfer) state_nxt = GET_LO;
            default:               state_nxt = GET_LO;
        endcase
    end

    // Capture incoming codeword bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cw_lo <= '0;
            cw_hi <= '0;
        end else if (in_xfer) begin
            if (state == GET_LO) begin
                cw_lo <= in_byte;
            end else begin
                cw_hi <= in_byte;
            end
        end
    end

    // Registered output stream: valid follows the next state so it never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_byte  <= '0;
            res_hi    <= '0;
        end else begin
            out_valid <= (state_nxt == PUT_LO) || (state_nxt == PUT_HI);
            if (state == CALC) begin
                out_byte <= lo_calc;
                res_hi   <= hi_calc;
            end else if ((state == PUT_LO) && out_xfer) begin
                out_byte <= res_hi;
            end
        end
    end

    // Status flags and saturating error counters, updated once per word.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags      <= FLAG_CLEAN;
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (state == CALC) begin
            flags <= flags_calc;
            if ((flags_calc == FLAG_SINGLE) && (cnt_single != '1)) begin
                cnt_single <= cnt_single + 1'b1;
            end
            if ((flags_calc == FLAG_DOUBLE) && (cnt_double != '1)) begin
                cnt_double <= cnt_double + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_secded_decoder.sv
// Randomized bench for secded_decoder with a behavioural decode model and
// an always-on output checker.
module tb_secded_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_byte;
    logic [1:0] flags;
    logic [7:0] cnt_single;
    logic [7:0] cnt_double;

    secded_decoder #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .flags(flags), .cnt_single(cnt_single), .cnt_double(cnt_double)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [1:0] fl;
        int         cs;
        int         cd;
    } exp_t;

    exp_t exp_q[$];
    int   m_cs = 0;
    int   m_cd = 0;
    bit   ophase = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   or_mode = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Decode rules: syndrome = XOR of set positions, overall parity, then extract.
    function automatic void model(input logic [15:0] cw_in, output logic [7:0] lo,
                                  output logic [7:0] hi, output logic [1:0] fl);
        logic [15:0] cw;
        int s;
        logic [10:0] d;
        cw = cw_in;
        s = 0;
        for (int k = 1; k < 16; k++) if (cw[k]) s = s ^ k;
        if ($countones(cw) % 2 == 1) begin
            fl = 2'b01;
            cw[s] = ~cw[s];
        end else if (s != 0) begin
            fl = 2'b10;
        end else begin
            fl = 2'b00;
        end
        d  = {cw[15:9], cw[7:5], cw[3]};
        lo = d[7:0];
        hi = {fl, 3'b000, d[10:8]};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        int s;
        cw = '0;
        cw[15:9] = d[10:4];
        cw[7:5]  = d[3:1];
        cw[3]    = d[0];
        s = 0;
        for (int k = 1; k < 16; k++) if (cw[k]) s = s ^ k;
        for (int i = 0; i < 4; i++) cw[1 << i] = s[i];
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic push_expect(input logic [15:0] cw);
        exp_t e;
        model(cw, e.lo, e.hi, e.fl);
        if (e.fl == 2'b01 && m_cs < 255) m_cs++;
        if (e.fl == 2'b10 && m_cd < 255) m_cd++;
        e.cs = m_cs;
        e.cd = m_cd;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] cw);
        send_byte(cw[7:0]);
        send_byte(cw[15:8]);
        push_expect(cw);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        ophase = 0;
        m_cs = 0;
        m_cd = 0;
        @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_flags", flags, 0);
        chk("rst_cnt_single", cnt_single, 0);
        chk("rst_cnt_double", cnt_double, 0);
    endtask

    // Consumer readiness, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare every presented output byte against the model queue.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            chk("in_ready_while_pending", in_ready, 0);
            if (exp_q.size() == 0) begin
                chk("out_valid_without_word", out_valid, 0);
            end else begin
                chk(ophase ? "out_byte_hi" : "out_byte_lo", out_byte,
                    ophase ? exp_q[0].hi : exp_q[0].lo);
                chk("flags", flags, exp_q[0].fl);
                chk("cnt_single", cnt_single, exp_q[0].cs);
                chk("cnt_double", cnt_double, exp_q[0].cd);
                if (out_ready) begin
                    if (ophase) void'(exp_q.pop_front());
                    ophase = ~ophase;
                end
            end
        end
    end

    initial begin
        logic [7:0]  lo, hi;
        logic [1:0]  fl;
        logic [15:0] cw;
        int          p1, p2, nerr, t;

        // Pin the model to hand-computed decodes.
        model(16'hFFFF, lo, hi, fl); chk("model_ffff", {hi, lo}, 16'h07FF);
        model(16'h7FFF, lo, hi, fl); chk("model_7fff", {hi, lo}, 16'h47FF);
        model(16'h0006, lo, hi, fl); chk("model_0006", {hi, lo}, 16'h8000);
        model(16'h0001, lo, hi, fl); chk("model_0001", {hi, lo}, 16'h4000);
        model(16'h0020, lo, hi, fl); chk("model_0020", {hi, lo}, 16'h4000);

        repeat (2) @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_flags", flags, 0);

        // Directed vectors.
        send_word(16'hFFFF); drain();
        chk("v1_flags", flags, 2'b00);
        chk("v1_cnt_single", cnt_single, 0);
        chk("v1_cnt_double", cnt_double, 0);
        send_word(16'h7FFF); drain();
        chk("v2_flags", flags, 2'b01);
        chk("v2_cnt_single", cnt_single, 1);
        send_word(16'h0006); drain();
        chk("v3_flags", flags, 2'b10);
        chk("v3_cnt_double", cnt_double, 1);
        send_word(16'h0001); drain();
        chk("v4_flags", flags, 2'b01);
        send_word(16'h0020); drain();
        chk("v4b_cnt_single", cnt_single, 3);

        // Backpressure while the low result byte is pending.
        or_mode = 2;
        @(posedge clk);
        send_word(16'h7FFF);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid", out_valid, 1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_lo_hold", out_byte, 8'hFF);
            chk("bp_in_ready", in_ready, 0);
        end
        or_mode = 0;
        drain();

        // Reset after the low byte of a word was accepted.
        send_byte(8'hAB);
        do_reset();
        send_word(16'h0000); drain();
        chk("fresh_flags", flags, 2'b00);
        chk("fresh_cnt_single", cnt_single, 0);

        // Random words with 0, 1 or 2 injected errors, random backpressure.
        or_mode = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                cw = 16'($urandom);
            end else begin
                cw = encode(11'($urandom));
                nerr = $urandom_range(0, 2);
                p1 = $urandom_range(0, 15);
                p2 = (p1 + $urandom_range(1, 15)) % 16;
                if (nerr >= 1) cw[p1] = ~cw[p1];
                if (nerr == 2) cw[p2] = ~cw[p2];
            end
            send_word(cw);
        end
        drain();
        or_mode = 0;

        // Saturation of the single-error counter.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cw = encode(11'($urandom));
            p1 = $urandom_range(0, 15);
            cw[p1] = ~cw[p1];
            send_word(cw);
        end
        drain();
        chk("sat_cnt_single", cnt_single, 255);
        chk("sat_cnt_double", cnt_double, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
